// File: rtl/mem_handle_responder_if.sv
// Request/response bundle of the mem_handle protocol between a region walker (master)
// and the memory-side responder (slave).
interface mem_handle_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              avail;
    logic              w_en;
    logic              r_en;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] data_store;
    logic              write_through;
    logic              read_through;
    logic              done;
    logic [DATA_W-1:0] data_load;
    logic              err;

    modport master (
        output avail, w_en, r_en, ptr, data_store, write_through, read_through,
        input  done, data_load, err
    );

    modport slave (
        input  avail, w_en, r_en, ptr, data_store, write_through, read_through,
        output done, data_load, err
    );
endinterface

// File: rtl/mem_handle_responder.sv
// Memory-side responder of the mem_handle protocol: one bounds-checked word access at a time
// into a single-port SRAM bank. Define MEM_POSTED_WRITE_EN for a one-entry posted write buffer.
module mem_handle_responder #(
    parameter int unsigned  ADDR_W    = 32,
    parameter int unsigned  DATA_W    = 32,
    parameter int unsigned  MEM_DEPTH = 1024,
    parameter int unsigned  RD_LAT    = 2,
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_l,
    mem_handle_responder_if.slave mh,
    input  logic [ADDR_W-1:0]     region_begin,
    input  logic [ADDR_W-1:0]     region_end,
    output logic [IDX_W-1:0]      sram_addr,
    output logic                  sram_we,
    output logic                  sram_re,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata
);
    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StResp,
        StAck
`ifdef MEM_POSTED_WRITE_EN
        , StDrain,
        StFwd
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  data_load_q, data_load_d;
    logic [IDX_W-1:0]   sram_addr_q, sram_addr_d;
    logic               sram_we_q, sram_we_d;
    logic               sram_re_q, sram_re_d;
    logic [DATA_W-1:0]  sram_wdata_q, sram_wdata_d;

    logic [IDX_W-1:0]   ptr_idx;
    logic               reject;

`ifdef MEM_POSTED_WRITE_EN
    logic               buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0]   buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]  buf_data_q, buf_data_d;
    // Request held while waiting in StDrain; the initiator may drop avail meanwhile.
    logic               req_we_q, req_we_d;
    logic [IDX_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]  req_wdata_q, req_wdata_d;
`else
    logic               unused_thru;
    assign unused_thru = mh.write_through ^ mh.read_through;
`endif

    assign ptr_idx = mh.ptr[IDX_W-1:0];
    assign reject  = (mh.ptr < region_begin) || (mh.ptr >= region_end) || (mh.w_en == mh.r_en);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        data_load_d  = data_load_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_d    = 1'b0;
        sram_re_d    = 1'b0;
`ifdef MEM_POSTED_WRITE_EN
        buf_valid_d  = buf_valid_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        req_we_d     = req_we_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (mh.avail) begin
                    if (reject) begin
                        state_d = StResp;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
`ifdef MEM_POSTED_WRITE_EN
                    else begin
                        req_we_d    = mh.w_en;
                        req_addr_d  = ptr_idx;
                        req_wdata_d = mh.data_store;
                        if (mh.w_en && !mh.write_through && !buf_valid_q) begin
                            buf_valid_d = 1'b1;
                            buf_addr_d  = ptr_idx;
                            buf_data_d  = mh.data_store;
                            state_d     = StResp;
                            done_d      = 1'b1;
                        end else if (mh.r_en && !mh.read_through && buf_valid_q &&
                                     (buf_addr_q == ptr_idx)) begin
                            state_d = StFwd;
                        end else if (buf_valid_q) begin
                            state_d = StDrain;
                        end else if (mh.w_en) begin
                            state_d      = StWr;
                            sram_we_d    = 1'b1;
                            sram_addr_d  = ptr_idx;
                            sram_wdata_d = mh.data_store;
                        end else begin
                            state_d     = StRd;
                            sram_re_d   = 1'b1;
                            sram_addr_d = ptr_idx;
                            cnt_d       = '0;
                        end
                    end
                end else if (buf_valid_q) begin
                    // Port is free next cycle: commit the posted write.
                    sram_we_d    = 1'b1;
                    sram_addr_d  = buf_addr_q;
                    sram_wdata_d = buf_data_q;
                    buf_valid_d  = 1'b0;
                end
`else
                    else if (mh.w_en) begin
                        state_d      = StWr;
                        sram_we_d    = 1'b1;
                        sram_addr_d  = ptr_idx;
                        sram_wdata_d = mh.data_store;
                    end else begin
                        state_d     = StRd;
                        sram_re_d   = 1'b1;
                        sram_addr_d = ptr_idx;
                        cnt_d       = '0;
                    end
                end
`endif
            end
            StWr: begin
                state_d = StResp;
                done_d  = 1'b1;
            end
            StRd: begin
                if (cnt_q == CNT_W'(RD_LAT)) begin
                    data_load_d = sram_rdata;
                    done_d      = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: state_d = StAck;
            StAck:  state_d = StIdle;
`ifdef MEM_POSTED_WRITE_EN
            StDrain: begin
                if (buf_valid_q) begin
                    sram_we_d    = 1'b1;
                    sram_addr_d  = buf_addr_q;
                    sram_wdata_d = buf_data_q;
                    buf_valid_d  = 1'b0;
                end else if (req_we_q) begin
                    state_d      = StWr;
                    sram_we_d    = 1'b1;
                    sram_addr_d  = req_addr_q;
                    sram_wdata_d = req_wdata_q;
                end else begin
                    state_d     = StRd;
                    sram_re_d   = 1'b1;
                    sram_addr_d = req_addr_q;
                    cnt_d       = '0;
                end
            end
            StFwd: begin
                data_load_d = buf_data_q;
                done_d      = 1'b1;
                state_d     = StResp;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            data_load_q  <= '0;
            sram_addr_q  <= '0;
            sram_we_q    <= 1'b0;
            sram_re_q    <= 1'b0;
            sram_wdata_q <= '0;
`ifdef MEM_POSTED_WRITE_EN
            buf_valid_q  <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            data_load_q  <= data_load_d;
            sram_addr_q  <= sram_addr_d;
            sram_we_q    <= sram_we_d;
            sram_re_q    <= sram_re_d;
            sram_wdata_q <= sram_wdata_d;
`ifdef MEM_POSTED_WRITE_EN
            buf_valid_q  <= buf_valid_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
`endif
        end
    end

    assign mh.done      = done_q;
    assign mh.err       = err_q;
    assign mh.data_load = data_load_q;
    assign sram_addr    = sram_addr_q;
    assign sram_we      = sram_we_q;
    assign sram_re      = sram_re_q;
    assign sram_wdata   = sram_wdata_q;
endmodule

// File: tb/tb_mem_handle_responder.sv
// Randomized bench for mem_handle_responder: an SRAM model with fixed read latency plus a
// word-level reference memory predicting err, data_load, latency and SRAM strobes.
module tb_mem_handle_responder;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_DEPTH = 64;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);

    logic              clk = 1'b0;
    logic              rst_l;
    logic [ADDR_W-1:0] region_begin, region_end;
    logic [IDX_W-1:0]  sram_addr;
    logic              sram_we, sram_re;
    logic [DATA_W-1:0] sram_wdata, sram_rdata;

    mem_handle_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mh ();

    mem_handle_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_l(rst_l), .mh(mh),
        .region_begin(region_begin), .region_end(region_end),
        .sram_addr(sram_addr), .sram_we(sram_we), .sram_re(sram_re),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: data appears RD_LAT cycles after the read strobe, garbage otherwise.
    logic [DATA_W-1:0] sram_mem [MEM_DEPTH];
    logic [DATA_W-1:0] rd_pipe  [RD_LAT];
    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_addr] <= sram_wdata;
        rd_pipe[0] <= sram_re ? sram_mem[sram_addr] : 32'hBAAD_F00D;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rdata = rd_pipe[RD_LAT-1];

    bit both_seen = 1'b0;
    always @(negedge clk) if (sram_we && sram_re) both_seen = 1'b1;

    logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
    logic [DATA_W-1:0] ref_load;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a sample point with the DUT idle; returns at the next idle sample point.
    task automatic do_req(input logic we, input logic re, input logic [ADDR_W-1:0] p,
                          input logic [DATA_W-1:0] d, input logic wt, input logic rt,
                          input bit drop_early, input int gap,
                          output int lat, output int n_we, output int n_re,
                          output int we_at, output int re_at);
        logic             exp_err;
        logic [IDX_W-1:0] idx, we_addr, re_addr;
        logic [DATA_W-1:0] we_data;
        bit               seen;
        exp_err = (p < region_begin) || (p >= region_end) || (we == re);
        idx     = p[IDX_W-1:0];
        repeat (gap) begin @(posedge clk); #1; end
        mh.avail = 1'b1; mh.w_en = we; mh.r_en = re; mh.ptr = p; mh.data_store = d;
        mh.write_through = wt; mh.read_through = rt;
        seen = 1'b0; lat = 0; n_we = 0; n_re = 0; we_at = 0; re_at = 0;
        we_addr = '0; re_addr = '0; we_data = '0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (sram_we) begin
                n_we++;
                if (we_at == 0) begin we_at = lat; we_addr = sram_addr; we_data = sram_wdata; end
            end
            if (sram_re) begin
                n_re++;
                if (re_at == 0) begin re_at = lat; re_addr = sram_addr; end
            end
            if (mh.done) seen = 1'b1;
            else if (drop_early && lat == 1) mh.avail = 1'b0;
        end
        check_eq("done_seen", seen, 1'b1);
        mh.avail = 1'b0;
        if (seen) begin
            check_eq("err", mh.err, exp_err);
            if (!exp_err && re) ref_load = ref_mem[idx];
            check_eq("data_load", mh.data_load, ref_load);
            if (!exp_err && we) ref_mem[idx] = d;
`ifndef MEM_POSTED_WRITE_EN
            check_eq("latency", lat, exp_err ? 1 : (we ? 2 : RD_LAT + 2));
            check_eq("sram_we_count", n_we, (!exp_err && we) ? 1 : 0);
            check_eq("sram_re_count", n_re, (!exp_err && re) ? 1 : 0);
            if (n_we == 1) begin
                check_eq("we_cycle", we_at, 1);
                check_eq("we_addr", we_addr, idx);
                check_eq("we_data", we_data, d);
            end
            if (n_re == 1) begin
                check_eq("re_cycle", re_at, 1);
                check_eq("re_addr", re_addr, idx);
            end
`endif
        end
        @(posedge clk); #1;
        check_eq("done_pulse", mh.done, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, nwe, nre, wat, rat;
        logic [ADDR_W-1:0] p, span;
        logic we, re, wt, rt;
        int kind, sel;
        mh.avail = 1'b0; mh.w_en = 1'b0; mh.r_en = 1'b0; mh.ptr = '0; mh.data_store = '0;
        mh.write_through = 1'b0; mh.read_through = 1'b0;
        region_begin = 32'h10; region_end = 32'h14;
        for (int i = 0; i < MEM_DEPTH; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
        ref_load = '0;
        rst_l = 1'b1; #2 rst_l = 1'b0; #1;
        check_eq("rst_done", mh.done, 1'b0);
        check_eq("rst_err", mh.err, 1'b0);
        check_eq("rst_data_load", mh.data_load, '0);
        check_eq("rst_we", sram_we, 1'b0);
        check_eq("rst_re", sram_re, 1'b0);
        check_eq("rst_addr", sram_addr, '0);
        check_eq("rst_wdata", sram_wdata, '0);
        repeat (2) @(posedge clk);
        #1 rst_l = 1'b1;
        @(posedge clk); #1;

        do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 0, lat, nwe, nre, wat, rat);
        do_req(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 0, lat, nwe, nre, wat, rat);
        check_eq("t2_data", mh.data_load, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h14, 32'h1234, 1'b1, 1'b0, 1'b0, 0, lat, nwe, nre, wat, rat);
        check_eq("t3_nowrite", nwe, 0);
        do_req(1'b1, 1'b1, 32'h11, 32'h5555, 1'b0, 1'b0, 1'b0, 0, lat, nwe, nre, wat, rat);
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 1'b0, 32'h10 + i, 32'h0, 1'b0, 1'b0, 1'b0, 0, lat, nwe, nre, wat, rat);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 1'b1, 32'h10 + i, 32'h0, 1'b0, 1'b0, 1'b0, 0, lat, nwe, nre, wat, rat);
            check_eq("walk_zero", mh.data_load, 32'h0);
        end

        // Reset in the middle of a read.
        do_req(1'b1, 1'b0, 32'h11, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 0, lat, nwe, nre, wat, rat);
        do_req(1'b0, 1'b1, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0, 3, lat, nwe, nre, wat, rat);
        repeat (3) begin @(posedge clk); #1; end
        mh.avail = 1'b1; mh.w_en = 1'b0; mh.r_en = 1'b1; mh.ptr = 32'h11; mh.read_through = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("abort_pre_done", mh.done, 1'b0);
        rst_l = 1'b0; #1;
        check_eq("abort_done", mh.done, 1'b0);
        check_eq("abort_data_load", mh.data_load, '0);
        check_eq("abort_re", sram_re, 1'b0);
        check_eq("abort_addr", sram_addr, '0);
        mh.avail = 1'b0;
        repeat (3) begin @(posedge clk); #1; check_eq("abort_no_done", mh.done, 1'b0); end
        rst_l = 1'b1; ref_load = '0;
        @(posedge clk); #1;
        do_req(1'b0, 1'b1, 32'h11, 32'h0, 1'b0, 1'b1, 1'b0, 0, lat, nwe, nre, wat, rat);
        check_eq("post_rst_read", mh.data_load, 32'hCAFEF00D);

`ifdef MEM_POSTED_WRITE_EN
        do_req(1'b1, 1'b0, 32'h12, 32'hA5, 1'b0, 1'b0, 1'b0, 0, lat, nwe, nre, wat, rat);
        check_eq("posted_wr_lat", lat, 1);
        check_eq("posted_wr_no_we", nwe, 0);
        do_req(1'b0, 1'b1, 32'h12, 32'h0, 1'b0, 1'b0, 1'b0, 0, lat, nwe, nre, wat, rat);
        check_eq("fwd_lat", lat, 2);
        check_eq("fwd_no_re", nre, 0);
        check_eq("fwd_data", mh.data_load, 32'hA5);
        do_req(1'b0, 1'b1, 32'h12, 32'h0, 1'b0, 1'b1, 1'b0, 0, lat, nwe, nre, wat, rat);
        check_eq("rt_drain_we", nwe, 1);
        check_eq("rt_re", nre, 1);
        check_eq("rt_drain_first", wat < rat, 1'b1);
`endif

        for (int b = 0; b < 10; b++) begin
            sel = $urandom_range(0, 2);
            region_begin = (sel == 0) ? 32'h10 : (sel == 1) ? 32'h1000_0040 : 32'hFFFF_FFC0;
            region_end   = region_begin + $urandom_range(0, 48);
            span         = region_end - region_begin;
            for (int k = 0; k < 15; k++) begin
                case ($urandom_range(0, 7))
                    0:       p = region_begin - 1;
                    1:       p = region_end;
                    2:       p = region_end - 1;
                    3:       p = region_begin;
                    default: p = (span == 0) ? region_begin : region_begin + ($urandom % span);
                endcase
                kind = $urandom_range(0, 9);
                we   = (kind < 4) || (kind == 9);
                re   = (kind >= 4 && kind < 8) || (kind == 9);
                wt   = 1'($urandom_range(0, 1));
                rt   = 1'($urandom_range(0, 1));
                do_req(we, re, p, $urandom, wt, rt, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 2), lat, nwe, nre, wat, rat);
            end
        end

        check_eq("we_re_exclusive", both_seen, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
